// File: rtl/aud_i2s_rx.sv
// rtl/aud_i2s_rx.sv - codec ADC-side I2S receiver with valid/ready sample output and SRAM addressing
module aud_i2s_rx #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'(20'hFFFFF),
  parameter int                SYNC_STAGES = 2,
  parameter bit                CHANNEL     = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_AUD_BCLK,
  input  logic              i_AUD_ADCLRCK,
  input  logic              i_AUD_ADCDAT,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_full,
  output logic              o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSED,
    S_WAIT_LR,
    S_DELAY,
    S_SHIFT,
    S_OUTPUT
  } state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t                   state, state_n;
  logic [SYNC_STAGES-1:0]   bclk_sync, lr_sync, dat_sync;
  logic                     bclk_d1, lr_d1;
  logic                     bclk_rise, lr_rise, lr_fall;
  logic                     bit_in, lr_enter, lr_edge;
  logic [DATA_W-1:0]        shreg, shreg_n, data_n;
  logic [CNT_W-1:0]         bit_cnt, bit_cnt_n;
  logic [ADDR_W-1:0]        addr_n;
  logic                     valid_n, full_n, ovr_n;
  logic                     pause_pend, pause_pend_n;

  // Synchronise the three asynchronous codec pins through identical chains
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i_AUD_BCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i_AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], i_AUD_ADCDAT};
    end
  end

  // Registered edge pulses, one cycle after the synchronised level changes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_d1   <= 1'b0;
      lr_d1     <= 1'b0;
      bclk_rise <= 1'b0;
      lr_rise   <= 1'b0;
      lr_fall   <= 1'b0;
    end else begin
      bclk_d1   <= bclk_sync[SYNC_STAGES-1];
      lr_d1     <= lr_sync[SYNC_STAGES-1];
      bclk_rise <= bclk_sync[SYNC_STAGES-1] & ~bclk_d1;
      lr_rise   <= lr_sync[SYNC_STAGES-1] & ~lr_d1;
      lr_fall   <= ~lr_sync[SYNC_STAGES-1] & lr_d1;
    end
  end

  assign bit_in   = dat_sync[SYNC_STAGES-1];
  assign lr_enter = CHANNEL ? lr_rise : lr_fall;
  assign lr_edge  = lr_rise | lr_fall;
  assign o_busy   = (state != S_IDLE) && (state != S_PAUSED);

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      o_data     <= '0;
      o_addr     <= '0;
      o_valid    <= 1'b0;
      o_full     <= 1'b0;
      o_overrun  <= 1'b0;
      pause_pend <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      o_data     <= data_n;
      o_addr     <= addr_n;
      o_valid    <= valid_n;
      o_full     <= full_n;
      o_overrun  <= ovr_n;
      pause_pend <= pause_pend_n;
    end
  end

  // Next-state and output logic; stop overrides pause, pause overrides start
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    data_n       = o_data;
    addr_n       = o_addr;
    valid_n      = o_valid;
    full_n       = o_full;
    ovr_n        = o_overrun;
    pause_pend_n = pause_pend;
    if (i_stop) begin
      state_n      = S_IDLE;
      valid_n      = 1'b0;
      addr_n       = '0;
      full_n       = 1'b0;
      ovr_n        = 1'b0;
      pause_pend_n = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_PAUSED: begin
          if (i_start && !i_pause) begin
            state_n = S_WAIT_LR;
            full_n  = 1'b0;
            ovr_n   = 1'b0;
          end
        end
        S_WAIT_LR: begin
          if (i_pause)       state_n = S_PAUSED;
          else if (lr_enter) state_n = S_DELAY;
        end
        S_DELAY: begin
          if (i_pause) begin
            state_n = S_PAUSED;
          end else if (lr_edge) begin
            state_n = lr_enter ? S_DELAY : S_WAIT_LR;
          end else if (bclk_rise) begin
            state_n   = S_SHIFT;
            bit_cnt_n = '0;
          end
        end
        S_SHIFT: begin
          if (i_pause) begin
            state_n = S_PAUSED;
          end else if (lr_edge) begin
            // Short frame: drop the partial word without flagging overrun
            state_n = lr_enter ? S_DELAY : S_WAIT_LR;
          end else if (bclk_rise) begin
            shreg_n = {shreg[DATA_W-2:0], bit_in};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              data_n  = {shreg[DATA_W-2:0], bit_in};
              valid_n = 1'b1;
              state_n = S_OUTPUT;
            end else begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (i_pause) pause_pend_n = 1'b1;
          if (o_valid && i_ready) begin
            valid_n      = 1'b0;
            pause_pend_n = 1'b0;
            if (o_addr == MAX_ADDR) begin
              full_n  = 1'b1;
              addr_n  = '0;
              state_n = S_IDLE;
            end else begin
              addr_n  = o_addr + ADDR_W'(1);
              state_n = (pause_pend || i_pause) ? S_PAUSED : S_WAIT_LR;
            end
          end else if (lr_enter) begin
            // Pending sample keeps priority; the new frame is lost
            ovr_n = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule
